// File: rtl/johnson_run_ctrl.sv
// rtl/johnson_run_ctrl.sv - Johnson ring run controller with revolution count, pause, direction, abort
module johnson_run_ctrl #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CW-1:0]   cycles,
  input  logic            pause,
  input  logic            dir,
  input  logic            abort,
  output logic [N-1:0]    q,
  output logic [2*N-1:0]  phase,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   cyc_left
);

  localparam int IW = $clog2(2*N) + 1;
  localparam logic [2*N-1:0] PHASE_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  q_nx, q_step;
  logic [CW-1:0] cyc_nx;
  logic [IW-1:0] pop, idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q        <= '0;
      cyc_left <= '0;
    end else begin
      state    <= state_nx;
      q        <= q_nx;
      cyc_left <= cyc_nx;
    end
  end

  always_comb begin
    q_step   = dir ? {~q[0], q[N-1:1]} : {q[N-2:0], ~q[N-1]};
    state_nx = state;
    q_nx     = q;
    cyc_nx   = cyc_left;
    case (state)
      IDLE: begin
        if (start && cycles != '0) begin
          state_nx = RUN;
          cyc_nx   = cycles;
          q_nx     = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          q_nx     = '0;
          cyc_nx   = '0;
        end else if (!pause) begin
          q_nx = q_step;
          // Only arrival at the all-zero state counts, whichever way the ring turns.
          if (q_step == '0 && q != '0) begin
            cyc_nx = cyc_left - CW'(1);
            if (cyc_left == CW'(1)) state_nx = DONE;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        q_nx     = '0;
        cyc_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        q_nx     = '0;
        cyc_nx   = '0;
      end
    endcase
  end

  // Rising half of the ring has q[0] set; the falling half mirrors around 2N.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + IW'(q[i]);
    idx   = (q == '0 || q[0]) ? pop : IW'(2*N) - pop;
    phase = PHASE_ONE << idx;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_johnson_run_ctrl.sv
// tb/tb_johnson_run_ctrl.sv - directed scoreboard bench for johnson_run_ctrl
module tb_johnson_run_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, dir, abort;
  logic [7:0] cycles;
  logic [3:0] q;
  logic [7:0] phase;
  logic       busy, done;
  logic [7:0] cyc_left;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic [7:0] cyc;
    logic [7:0] phase;
  } exp_t;

  exp_t sb[$];

  logic [3:0] fwd [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] turn_seq [14] = '{4'h1, 4'h3, 4'h7, 4'h3, 4'h1, 4'h0,
                                4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

  johnson_run_ctrl #(.N(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cycles(cycles), .pause(pause),
    .dir(dir), .abort(abort), .q(q), .phase(phase), .busy(busy), .done(done),
    .cyc_left(cyc_left)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] phase_of(input logic [3:0] v);
    for (int i = 0; i < 8; i++) if (fwd[i] == v) return 8'(1) << i;
    return 8'h00;
  endfunction

  task automatic step(input string tag, input logic [3:0] eq, input logic eb,
                      input logic ed, input logic [7:0] ec);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed; e.cyc = ec; e.phase = phase_of(eq);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    assert (q === e.q) else begin
      fails++; $error("FAIL %s q got %h exp %h", e.tag, q, e.q);
    end
    tests++;
    assert (busy === e.busy) else begin
      fails++; $error("FAIL %s busy got %b exp %b", e.tag, busy, e.busy);
    end
    tests++;
    assert (done === e.done) else begin
      fails++; $error("FAIL %s done got %b exp %b", e.tag, done, e.done);
    end
    tests++;
    assert (cyc_left === e.cyc) else begin
      fails++; $error("FAIL %s cyc_left got %0d exp %0d", e.tag, cyc_left, e.cyc);
    end
    tests++;
    assert (phase === e.phase) else begin
      fails++; $error("FAIL %s phase got %h exp %h", e.tag, phase, e.phase);
    end
  endtask

  initial begin
    int pos, left;
    logic paused;
    reset = 1'b1; start = 1'b0; pause = 1'b0; dir = 1'b0; abort = 1'b0; cycles = 8'd0;
    #1;
    step("reset0", 4'h0, 1'b0, 1'b0, 8'd0);
    step("reset1", 4'h0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    step("idle", 4'h0, 1'b0, 1'b0, 8'd0);

    // single forward revolution
    start = 1'b1; cycles = 8'd1; dir = 1'b0;
    step("fw_start", 4'h0, 1'b1, 1'b0, 8'd1);
    start = 1'b0;
    for (int i = 1; i <= 8; i++)
      step("fw_run", fwd[i % 8], 1'b1, (i == 8), (i == 8) ? 8'd0 : 8'd1);
    step("fw_idle", 4'h0, 1'b0, 1'b0, 8'd0);

    // three reverse revolutions
    start = 1'b1; cycles = 8'd3; dir = 1'b1;
    step("rv_start", 4'h0, 1'b1, 1'b0, 8'd3);
    start = 1'b0;
    for (int j = 1; j <= 24; j++)
      step("rv_run", fwd[(8 - (j % 8)) % 8], 1'b1, (j == 24), 8'(3 - j / 8));
    step("rv_idle", 4'h0, 1'b0, 1'b0, 8'd0);

    // two revolutions with five pause cycles: done moves from step 16 to 21
    start = 1'b1; cycles = 8'd2; dir = 1'b0;
    step("pz_start", 4'h0, 1'b1, 1'b0, 8'd2);
    start = 1'b0;
    pos = 0; left = 2;
    for (int s = 1; s <= 21; s++) begin
      paused = (s >= 4 && s <= 8);
      pause = paused;
      if (!paused) begin
        pos = (pos + 1) % 8;
        if (pos == 0) left--;
      end
      step("pz_run", fwd[pos], 1'b1, (s == 21), 8'(left));
    end
    pause = 1'b0;
    step("pz_idle", 4'h0, 1'b0, 1'b0, 8'd0);

    // direction flip at q=7: retrace to 0 counts as a wrap
    start = 1'b1; cycles = 8'd2; dir = 1'b0;
    step("tn_start", 4'h0, 1'b1, 1'b0, 8'd2);
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) dir = 1'b1;
      step("tn_run", turn_seq[k], 1'b1, (k == 13), (k < 5) ? 8'd2 : (k < 13) ? 8'd1 : 8'd0);
    end
    step("tn_idle", 4'h0, 1'b0, 1'b0, 8'd0);

    // abort at q=E, then reset at q=E, with pause also high to confirm priority
    for (int r = 0; r < 2; r++) begin
      start = 1'b1; cycles = 8'd4; dir = 1'b0;
      step("ab_start", 4'h0, 1'b1, 1'b0, 8'd4);
      start = 1'b0;
      for (int i = 1; i <= 5; i++) step("ab_run", fwd[i], 1'b1, 1'b0, 8'd4);
      pause = 1'b1;
      if (r == 0) abort = 1'b1; else reset = 1'b1;
      step(r == 0 ? "ab_abort" : "ab_reset", 4'h0, 1'b0, 1'b0, 8'd0);
      abort = 1'b0; reset = 1'b0; pause = 1'b0;
      for (int i = 0; i < 10; i++) step("ab_quiet", 4'h0, 1'b0, 1'b0, 8'd0);
    end

    // start with cycles=0, start while busy, start during DONE
    start = 1'b1; cycles = 8'd0;
    step("z_ignored", 4'h0, 1'b0, 1'b0, 8'd0);
    cycles = 8'd1;
    step("ig_start", 4'h0, 1'b1, 1'b0, 8'd1);
    cycles = 8'd5;
    for (int i = 1; i <= 8; i++)
      step("ig_run", fwd[i % 8], 1'b1, (i == 8), (i == 8) ? 8'd0 : 8'd1);
    step("ig_done_exit", 4'h0, 1'b0, 1'b0, 8'd0);
    start = 1'b0;
    step("ig_idle0", 4'h0, 1'b0, 1'b0, 8'd0);
    step("ig_idle1", 4'h0, 1'b0, 1'b0, 8'd0);

    // maximum count accepted; one revolution decrements it
    start = 1'b1; cycles = 8'd255; dir = 1'b0;
    step("mx_start", 4'h0, 1'b1, 1'b0, 8'd255);
    start = 1'b0;
    for (int i = 1; i <= 8; i++)
      step("mx_run", fwd[i % 8], 1'b1, 1'b0, (i == 8) ? 8'd254 : 8'd255);
    abort = 1'b1;
    step("mx_abort", 4'h0, 1'b0, 1'b0, 8'd0);
    abort = 1'b0;
    step("mx_idle", 4'h0, 1'b0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
